// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low seven-segment code constants.
// Segment bit order is g..a in bits 6..0; a 0 bit lights the segment.
// The decimal point is handled separately by the scan driver.
package seg7_pkg;

    // Hex glyphs 0..F, entry 0 in the low slice: 0 1 2 3 4 5 6 7 8 9 A b C d E F.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [7:0] CATH_OFF = 8'hFF;

endpackage

// File: rtl/seg7_nibble_enc.sv
// seg7_nibble_enc: combinational nibble to active-low segment decoder.
// Ports: nibble - 4-bit digit value
//        hex_en - 1 shows 10..15 as A b C d E F, 0 shows them as a dash
//        seg    - active-low segments g..a
module seg7_nibble_enc
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] seg
);

    assign seg = (!hex_en && nibble > 4'd9) ? SEG_DASH : SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed scan driver for a common-anode seven-segment display.
// Ports: clk, rst_n     - clock, asynchronous active-low reset
//        load           - one-cycle request to capture value, dp_mask and blank_lz
//        value          - one nibble per digit, nibble 0 is the rightmost digit
//        dp_mask        - per-digit decimal point, 1 = lit
//        blank_lz       - 1 = blank leading zeros
//        cathode        - active-low segments, bit7 = dp, bits 6..0 = g..a
//        anode          - active-low digit enables, at most one low
//        frame_tick     - one-cycle pulse after each completed scan of all digits
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit HEX_EN      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [7:0]              cathode,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    slot_end;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    sh_blz;
    logic                    act_blz;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              nib;
    logic [6:0]              seg;
    logic                    blanked;

    assign slot_end  = cnt == CNT_LAST;
    assign frame_end = slot_end && idx == IDX_LAST;

    // Scan position: refresh counter within a slot, digit index across slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end)
                idx <= idx == IDX_LAST ? '0 : idx + IW'(1);
        end
    end

    // Double buffering: active registers only change at a frame boundary so a
    // frame never shows a mix of old and new digits. A load landing exactly on
    // the boundary bypasses the shadow and takes effect from digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val  <= '0;
            sh_dp   <= '0;
            sh_blz  <= 1'b0;
            act_val <= '0;
            act_dp  <= '0;
            act_blz <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_mask;
                sh_blz <= blank_lz;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (load) begin
                    act_val <= value;
                    act_dp  <= dp_mask;
                    act_blz <= blank_lz;
                end else if (pending) begin
                    act_val <= sh_val;
                    act_dp  <= sh_dp;
                    act_blz <= sh_blz;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // zero_from[i]: nibble i and every more-significant nibble are zero.
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            zero_from[i] = (act_val >> (4 * i)) == '0;
    end

    assign nib     = act_val[{idx, 2'b00} +: 4];
    assign blanked = act_blz && idx != '0 && zero_from[idx];

    seg7_nibble_enc u_enc (
        .nibble (nib),
        .hex_en (HEX_EN),
        .seg    (seg)
    );

    // Registered outputs; counter value 0 of each slot is dark so the previous
    // digit's segments never bleed onto the next anode while it switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode      <= '1;
            cathode    <= CATH_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            anode      <= cnt == '0 ? '1 : ~(NUM_DIGITS'(1) << idx);
            cathode    <= cnt == '0 ? CATH_OFF : {~act_dp[idx], blanked ? SEG_OFF : seg};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver (4-digit hex, 4-digit no-hex, 1-digit).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [7:0]  cat_h, cat_n, cat_1;
    logic [3:0]  an_h, an_n;
    logic [0:0]  an_1;
    logic        ft_h, ft_n, ft_1;
    int          tests = 0;
    int          fails = 0;
    logic [19:0] sb [$];
    logic [7:0]  tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .cathode(cat_h), .anode(an_h), .frame_tick(ft_h)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .cathode(cat_n), .anode(an_n), .frame_tick(ft_n)
    );

    seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(4), .HEX_EN(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value[3:0]), .dp_mask(dp_mask[0:0]),
        .blank_lz(blank_lz), .cathode(cat_1), .anode(an_1), .frame_tick(ft_1)
    );

    function automatic logic [7:0] exp_cat(input logic [15:0] v, input logic [3:0] dp,
                                           input logic blz, input int d, input bit hex);
        logic [3:0] n;
        logic [7:0] c;
        n = v[4*d +: 4];
        c = (!hex && n > 4'd9) ? 8'hBF : tab[n];
        if (blz && d != 0 && (v >> (4 * d)) == 16'h0)
            c = 8'hFF;
        if (dp[d])
            c[7] = 1'b0;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Each digit is lit for three cycles of its four-cycle slot.
    task automatic expect_frame(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        logic [3:0] an;
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d);
            repeat (3) sb.push_back({an, exp_cat(v, dp, blz, d, 1'b1), exp_cat(v, dp, blz, d, 1'b0)});
        end
    endtask

    // Checks one 16-cycle frame starting right after a frame boundary; optionally
    // pulses load after sample load_at.
    task automatic check_frame(input int load_at, input logic [15:0] lv,
                               input logic [3:0] lm, input logic lb);
        logic [19:0] e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i % 4 == 0) begin
                chk("guard_anode", an_h, 4'hF);
                chk("guard_cathode", cat_h, 8'hFF);
                chk("guard_cathode_nohex", cat_n, 8'hFF);
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL scoreboard_empty: got 0 entries expected >0 at step %0d", i);
            end else begin
                e = sb.pop_front();
                chk("anode", an_h, e[19:16]);
                chk("anode_nohex", an_n, e[19:16]);
                chk("cathode", cat_h, e[15:8]);
                chk("cathode_nohex", cat_n, e[7:0]);
            end
            chk("frame_tick", ft_h, i == 15);
            chk("frame_tick_nohex", ft_n, i == 15);
            chk("anode_1dig", an_1, i % 4 == 0);
            chk("frame_tick_1dig", ft_1, i % 4 == 3);
            load = i == load_at;
            if (i == load_at) begin
                value    = lv;
                dp_mask  = lm;
                blank_lz = lb;
            end
        end
    endtask

    task automatic chk_reset();
        chk("rst_anode", an_h, 4'hF);
        chk("rst_cathode", cat_h, 8'hFF);
        chk("rst_frame_tick", ft_h, 1'b0);
        chk("rst_anode_1dig", an_1, 1'b1);
        chk("rst_cathode_1dig", cat_1, 8'hFF);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        expect_frame(16'h0000, 4'h0, 1'b0);
        check_frame(5, 16'h1234, 4'h0, 1'b0);
        expect_frame(16'h1234, 4'h0, 1'b0);
        check_frame(14, 16'h0050, 4'h0, 1'b1);
        expect_frame(16'h0050, 4'h0, 1'b1);
        check_frame(5, 16'h0000, 4'b0100, 1'b1);
        expect_frame(16'h0000, 4'b0100, 1'b1);
        check_frame(14, 16'h00AF, 4'h0, 1'b0);
        expect_frame(16'h00AF, 4'h0, 1'b0);
        check_frame(-1, 16'h0000, 4'h0, 1'b0);
        @(negedge clk);
        value    = 16'h9876;
        dp_mask  = 4'hF;
        blank_lz = 1'b0;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("pre_reset_anode", an_h, 4'b1110);
        chk("pre_reset_cathode", cat_h, 8'h8E);
        #1 rst_n = 1'b0;
        #1 chk_reset();
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        expect_frame(16'h0000, 4'h0, 1'b0);
        check_frame(-1, 16'h0000, 4'h0, 1'b0);
        expect_frame(16'h0000, 4'h0, 1'b0);
        check_frame(-1, 16'h0000, 4'h0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range >= 4.
REQ-003 SHALL have parameter HEX_EN, default 1; 1 = nibbles 10..15 shown as A,b,C,d,E,F; 0 = shown as '-'.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port load, input, 1, one-cycle request to capture value, dp_mask and blank_lz.
REQ-007 SHALL have port value, input, 4*NUM_DIGITS, BCD/hex nibbles; nibble 0 is the rightmost digit.
REQ-008 SHALL have port dp_mask, input, NUM_DIGITS, decimal point on per digit, 1 = lit.
REQ-009 SHALL have port blank_lz, input, 1, 1 = blank leading zeros.
REQ-010 SHALL have port cathode, output, 8, active-low segments; bit7 = dp, bits 6..0 = g..a.
REQ-011 SHALL have port anode, output, NUM_DIGITS, active-low digit enables; at most one bit low at any time.
REQ-012 SHALL have port frame_tick, output, 1, one-cycle pulse when a full scan of all digits completes.

Function
REQ-013 SHALL hold a refresh counter counting 0..REFRESH_DIV-1; slot_end = counter at REFRESH_DIV-1; the counter wraps to 0.
REQ-014 SHALL advance the digit index on slot_end; the index wraps from NUM_DIGITS-1 to 0, and that wrap is frame_end.
REQ-015 SHALL assert frame_tick in the cycle after frame_end, for exactly one cycle.
REQ-016 SHALL capture inputs on load into shadow registers and set a pending flag; a later load before transfer overwrites the shadow.
REQ-017 SHALL copy shadow to active registers and clear pending on frame_end only, so that no frame mixes old and new values.
REQ-018 SHALL, when load coincides with frame_end, write the load inputs directly into the active registers and leave pending clear.
REQ-019 SHALL register the anode and cathode outputs, which reflect the digit index with one cycle of latency.
REQ-020 SHALL drive anode all-high and cathode 8'hFF during counter value 0 of every slot, as an anti-ghosting guard.
REQ-021 SHALL encode active-low segments: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, '-'=BF (bit7 shown as 1).
REQ-022 SHALL treat a digit as blanked when blank_lz=1, its nibble is 0, all more-significant nibbles are 0, and the digit is not digit 0.
REQ-023 SHALL drive segments 6..0 high for a blanked digit.
REQ-024 SHALL drive cathode[7] low when the dp_mask bit of the current digit is 1, including on blanked digits.
REQ-025 SHALL, when NUM_DIGITS=1, assert frame_end on every slot_end, and anode SHALL be 1 bit wide.

Reset
REQ-026 SHALL, on rst_n low, immediately clear the counter, index, active/shadow registers and pending; set anode to all-1, cathode to 8'hFF and frame_tick to 0.
REQ-027 SHALL discard an in-progress frame or a pending load on reset; after release, the scan restarts at digit 0 with counter 0 and shows value 0.

Structure
REQ-028 SHALL place the segment code constants (hex table, SEG_DASH, SEG_OFF) in shared package seg7_pkg.
REQ-029 SHALL implement nibble-to-segment decoding as combinational sub-module seg7_nibble_enc (nibble, hex_en -> seg[6:0]).

Verification
REQ-030 SHALL cover: NUM_DIGITS=4, REFRESH_DIV=4, load value=16'h1234 -> anodes low in order 1110,1101,1011,0111; cathodes 99,B0,A4,F9; frame_tick every 16 cycles.
REQ-031 SHALL cover: value=16'h0050, blank_lz=1 -> digits 3,2 give cathode FF; digit1=92; digit0=C0.
REQ-032 SHALL cover: value=16'h0000, blank_lz=1, dp_mask=4'b0100 -> digit0=C0, digit2=7F, others FF.
REQ-033 SHALL cover: HEX_EN=0, value=16'h00AF -> digits 1,0 both BF; HEX_EN=1 -> 88 and 8E.
REQ-034 SHALL cover: load mid-frame -> old value until frame_end; load exactly at frame_end -> new value from digit 0 onward.
REQ-035 SHALL cover: rst_n pulsed low mid-slot -> outputs reach reset values without a clock edge; after release, scan resumes at digit 0 showing 0.
